// File: rtl/uart_loader_pkg.sv
// Shared encodings for the UART boot/reload packet loader.
package uart_loader_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_LEN   = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_CHECK = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_CMD   = ST_CMD,
        S_ADDR  = ST_ADDR,
        S_LEN   = ST_LEN,
        S_DATA  = ST_DATA,
        S_CHECK = ST_CHECK
    } state_e;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_JUMP  = 8'h02;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_BAD_CMD = 3'd1;
    localparam logic [2:0] ERR_CHKSUM  = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_OVERRUN = 3'd4;

endpackage

// File: rtl/uart_rx_loader.sv
// Framed load protocol parser: turns UART bytes into word writes
// and a boot jump request.
module uart_rx_loader
    import uart_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 1000000
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_Mem_Wr,
    output logic [31:0] o_Mem_Addr,
    output logic [31:0] o_Mem_Data,
    input  logic        i_Mem_Ready,
    output logic        o_Jump,
    output logic [31:0] o_Jump_Addr,
    output logic        o_Busy,
    output logic        o_Done,
    output logic [2:0]  o_Error
);

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CLKS - 1);

    state_e      state_q, state_d;
    logic        jump_cmd_q, jump_cmd_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] len_q, len_d;
    logic [23:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  chk_q, chk_d;
    logic [31:0] tmo_q, tmo_d;
    logic        wr_q, wr_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        jump_q, jump_d;
    logic [31:0] jump_addr_q, jump_addr_d;
    logic        done_q, done_d;
    logic [2:0]  err_q, err_d;

    logic        wr_blocked;
    logic [15:0] len_next;
    logic [31:0] word_next;

    assign wr_blocked = wr_q && !i_Mem_Ready;
    assign len_next   = {i_Rx_Byte, len_q[15:8]};
    assign word_next  = {i_Rx_Byte, word_q};

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state_q     <= S_IDLE;
            jump_cmd_q  <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            word_q      <= '0;
            cnt_q       <= '0;
            chk_q       <= '0;
            tmo_q       <= '0;
            wr_q        <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            jump_q      <= 1'b0;
            jump_addr_q <= '0;
            done_q      <= 1'b0;
            err_q       <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            jump_cmd_q  <= jump_cmd_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            chk_q       <= chk_d;
            tmo_q       <= tmo_d;
            wr_q        <= wr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            jump_q      <= jump_d;
            jump_addr_q <= jump_addr_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        jump_cmd_d  = jump_cmd_q;
        addr_d      = addr_q;
        len_d       = len_q;
        word_d      = word_q;
        cnt_d       = cnt_q;
        chk_d       = chk_q;
        tmo_d       = tmo_q + 32'd1;
        wr_d        = wr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        jump_d      = 1'b0;
        jump_addr_d = jump_addr_q;
        done_d      = 1'b0;
        err_d       = err_q;

        if (wr_q && i_Mem_Ready) begin
            wr_d = 1'b0;
        end
        if (state_q == S_IDLE) begin
            tmo_d = '0;
        end

        if (i_Rx_DV) begin
            tmo_d = '0;
            unique case (state_q)
                S_IDLE: begin
                    if (i_Rx_Byte == SYNC_BYTE) begin
                        state_d = S_CMD;
                        err_d   = ERR_NONE;
                        chk_d   = '0;
                        cnt_d   = '0;
                    end
                end
                S_CMD: begin
                    chk_d = chk_q ^ i_Rx_Byte;
                    cnt_d = '0;
                    if (i_Rx_Byte == CMD_WRITE || i_Rx_Byte == CMD_JUMP) begin
                        jump_cmd_d = (i_Rx_Byte == CMD_JUMP);
                        state_d    = S_ADDR;
                    end else begin
                        err_d   = ERR_BAD_CMD;
                        state_d = S_IDLE;
                    end
                end
                S_ADDR: begin
                    chk_d  = chk_q ^ i_Rx_Byte;
                    cnt_d  = cnt_q + 2'd1;
                    addr_d = {i_Rx_Byte, addr_q[31:8]};
                    if (cnt_q == 2'd3) begin
                        // word-align the target as the last byte lands
                        addr_d  = {i_Rx_Byte, addr_q[31:10], 2'b00};
                        state_d = jump_cmd_q ? S_CHECK : S_LEN;
                    end
                end
                S_LEN: begin
                    chk_d = chk_q ^ i_Rx_Byte;
                    len_d = len_next;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd1) begin
                        cnt_d   = '0;
                        state_d = (len_next == '0) ? S_CHECK : S_DATA;
                    end
                end
                S_DATA: begin
                    chk_d  = chk_q ^ i_Rx_Byte;
                    cnt_d  = cnt_q + 2'd1;
                    word_d = word_next[31:8];
                    if (cnt_q == 2'd3) begin
                        if (wr_blocked) begin
                            err_d   = ERR_OVERRUN;
                            state_d = S_IDLE;
                        end else begin
                            wr_d      = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = word_next;
                            addr_d    = addr_q + 32'd4;
                            len_d     = len_q - 16'd1;
                            if (len_q == 16'd1) begin
                                state_d = S_CHECK;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    state_d = S_IDLE;
                    if (i_Rx_Byte == chk_q) begin
                        done_d = 1'b1;
                        if (jump_cmd_q) begin
                            jump_d      = 1'b1;
                            jump_addr_d = addr_q;
                        end
                    end else begin
                        err_d = ERR_CHKSUM;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && tmo_q == TMO_LAST) begin
            err_d   = ERR_TIMEOUT;
            state_d = S_IDLE;
            tmo_d   = '0;
        end
    end

    assign o_Mem_Wr    = wr_q;
    assign o_Mem_Addr  = wr_addr_q;
    assign o_Mem_Data  = wr_data_q;
    assign o_Jump      = jump_q;
    assign o_Jump_Addr = jump_addr_q;
    assign o_Done      = done_q;
    assign o_Error     = err_q;
    assign o_Busy      = (state_q != S_IDLE) || wr_q;

endmodule

// File: tb/tb_uart_rx_loader.sv
// Directed bench for uart_rx_loader with a short timeout.
module tb_uart_rx_loader;

    logic        clk;
    logic        rst_n;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        jump;
    logic [31:0] jump_addr;
    logic        busy;
    logic        done;
    logic [2:0]  err;

    int n_vec;
    int n_err;
    int n_done;
    int n_jump;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [7:0]  q[$];

    uart_rx_loader #(
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CLKS(50)
    ) dut (
        .i_Clock(clk),
        .i_Reset_n(rst_n),
        .i_Rx_DV(rx_dv),
        .i_Rx_Byte(rx_byte),
        .o_Mem_Wr(mem_wr),
        .o_Mem_Addr(mem_addr),
        .o_Mem_Data(mem_data),
        .i_Mem_Ready(mem_ready),
        .o_Jump(jump),
        .o_Jump_Addr(jump_addr),
        .o_Busy(busy),
        .o_Done(done),
        .o_Error(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr && mem_ready) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_data);
        end
        if (done) n_done <= n_done + 1;
        if (jump) n_jump <= n_jump + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_q();
        foreach (q[i]) send(q[i]);
    endtask

    int nw;
    int nd;
    int nj;

    initial begin
        n_vec = 0; n_err = 0; n_done = 0; n_jump = 0;
        rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_wr",    {31'd0, mem_wr}, 32'd0);
        chk("rst_addr",  mem_addr, 32'd0);
        chk("rst_data",  mem_data, 32'd0);
        chk("rst_jaddr", jump_addr, 32'd0);
        chk("rst_flags", {28'd0, busy, done, jump, 1'b0}, 32'd0);
        chk("rst_err",   {29'd0, err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // two-word write; checksum 0x39 is the XOR of bytes 01..DE
        q = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00,
              8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h39};
        send_q();
        chk("wr_count", wa.size(), 32'd2);
        if (wa.size() == 2) begin
            chk("wr0_addr", wa[0], 32'h0000_1000);
            chk("wr0_data", wd[0], 32'h1234_5678);
            chk("wr1_addr", wa[1], 32'h0000_1004);
            chk("wr1_data", wd[1], 32'hDEAD_BEEF);
        end
        chk("wr_done", n_done, 32'd1);
        chk("wr_err",  {29'd0, err}, 32'd0);
        chk("wr_busy", {31'd0, busy}, 32'd0);
        chk("wr_nojump", n_jump, 32'd0);

        q = '{8'hA5, 8'h07};
        send_q();
        chk("badcmd_err",  {29'd0, err}, 32'd1);
        chk("badcmd_busy", {31'd0, busy}, 32'd0);

        send(8'hA5);
        chk("sync_clr_err",  {29'd0, err}, 32'd0);
        chk("sync_busy",     {31'd0, busy}, 32'd1);
        q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h80};
        send_q();
        nd = n_done;
        nj = n_jump;
        @(negedge clk);
        rx_dv = 1'b1; rx_byte = 8'h82;
        @(negedge clk);
        rx_dv = 1'b0;
        chk("jmp_pulse", {30'd0, jump, done}, 32'd3);
        chk("jmp_addr",  jump_addr, 32'h8000_0000);
        @(negedge clk);
        chk("jmp_onecyc", {30'd0, jump, done}, 32'd0);
        chk("jmp_count",  n_jump - nj, 32'd1);
        chk("jmp_done",   n_done - nd, 32'd1);
        chk("jmp_err",    {29'd0, err}, 32'd0);
        chk("jmp_held",   jump_addr, 32'h8000_0000);

        nj = n_jump;
        nd = n_done;
        q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00};
        send_q();
        chk("badchk_err",  {29'd0, err}, 32'd2);
        chk("badchk_jump", n_jump - nj, 32'd0);
        chk("badchk_done", n_done - nd, 32'd0);

        // overrun: address low bits 2'b11 must be dropped
        nw = wa.size();
        mem_ready = 1'b0;
        q = '{8'hA5, 8'h01, 8'h03, 8'h20, 8'h00, 8'h00, 8'h02, 8'h00,
              8'h11, 8'h22, 8'h33, 8'h44};
        send_q();
        chk("ovr_wr1",   {31'd0, mem_wr}, 32'd1);
        chk("ovr_addr1", mem_addr, 32'h0000_2000);
        chk("ovr_data1", mem_data, 32'h4433_2211);
        q = '{8'h55, 8'h66, 8'h77};
        send_q();
        chk("ovr_stable_a", mem_addr, 32'h0000_2000);
        chk("ovr_stable_d", mem_data, 32'h4433_2211);
        chk("ovr_pre_err",  {29'd0, err}, 32'd0);
        send(8'h88);
        chk("ovr_err",   {29'd0, err}, 32'd4);
        chk("ovr_busy",  {31'd0, busy}, 32'd1);
        chk("ovr_addr2", mem_addr, 32'h0000_2000);
        chk("ovr_data2", mem_data, 32'h4433_2211);
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ovr_wr_drop", {30'd0, busy, mem_wr}, 32'd0);
        chk("ovr_accept",  wa.size() - nw, 32'd1);
        if (wa.size() == nw + 1) begin
            chk("ovr_acc_a", wa[nw], 32'h0000_2000);
            chk("ovr_acc_d", wd[nw], 32'h4433_2211);
        end

        // timeout: error lands exactly 50 clocks after the last strobe
        send(8'hA5);
        send(8'h01);
        @(negedge clk);
        rx_dv = 1'b1; rx_byte = 8'h00;
        @(negedge clk);
        rx_dv = 1'b0;
        repeat (49) @(negedge clk);
        chk("tmo_early", {29'd0, err}, 32'd0);
        chk("tmo_busy0", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("tmo_err",  {29'd0, err}, 32'd3);
        chk("tmo_busy", {31'd0, busy}, 32'd0);

        // reset mid-DATA with a write pending
        nw = wa.size();
        mem_ready = 1'b0;
        q = '{8'hA5, 8'h01, 8'h00, 8'h30, 8'h00, 8'h00, 8'h02, 8'h00,
              8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
        send_q();
        chk("mid_wr",   {31'd0, mem_wr}, 32'd1);
        chk("mid_data", mem_data, 32'hDDCC_BBAA);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_wr",    {31'd0, mem_wr}, 32'd0);
        chk("mrst_addr",  mem_addr, 32'd0);
        chk("mrst_data",  mem_data, 32'd0);
        chk("mrst_jaddr", jump_addr, 32'd0);
        chk("mrst_flags", {28'd0, busy, done, jump, 1'b0}, 32'd0);
        chk("mrst_err",   {29'd0, err}, 32'd0);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("mrst_nowr", wa.size() - nw, 32'd0);
        chk("mrst_idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
